// File: rtl/stop_watch_pkg.sv
// Shared state encoding and defaults for the stopwatch control block.
// Feature macro: STOP_WATCH_CTRL_LAP_EN enables the LAP state.
package stop_watch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2,
        ST_LAP  = 2'd3
    } state_e;

    localparam int DEB_CYCLES_DEF = 20;

endpackage

// File: rtl/btn_debounce.sv
// Raw push button: 2-flop synchronizer, debouncer, rising-edge press pulse.
// Feature macro: none (used by stop_watch_ctrl, see STOP_WATCH_CTRL_LAP_EN).
module btn_debounce
    import stop_watch_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    r_sync;
    logic          r_lvl;
    logic          r_lvl_q;
    logic [CW-1:0] r_cnt;

    // Sync the raw level, then flip the debounced level after a full run
    // of mismatching cycles; any agreeing cycle restarts the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_lvl   <= 1'b0;
            r_lvl_q <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_lvl_q <= r_lvl;
            if (r_sync[1] == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
                r_lvl <= r_sync[1];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // One-cycle press pulse on the debounced rising edge only.
    assign o_press = r_lvl & ~r_lvl_q;

endmodule

// File: rtl/stop_watch_ctrl.sv
// Stopwatch control FSM driven by two debounced push buttons.
// Feature macro: STOP_WATCH_CTRL_LAP_EN enables the LAP/display-freeze state.
module stop_watch_ctrl
    import stop_watch_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_lap,
    output logic       enable,
    output logic       zero,
    output logic       lap_hold,
    output logic [1:0] state
);

    logic   w_start;
    logic   w_lap;
    state_e r_state;
    state_e w_next;
    logic   w_en_nx;
    logic   w_hold_nx;
    logic   w_zero_nx;
    logic   r_enable;
    logic   r_zero;
    logic   r_lap_hold;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_start),
        .o_press (w_start)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_lap),
        .o_press (w_lap)
    );

    // State and registered outputs, loaded from the next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_enable   <= 1'b0;
            r_zero     <= 1'b0;
            r_lap_hold <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_enable   <= w_en_nx;
            r_zero     <= w_zero_nx;
            r_lap_hold <= w_hold_nx;
        end
    end

    // Next state; start is tested first so it wins over a same-cycle lap.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start) w_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_start) begin
                    w_next = ST_STOP;
                end else if (w_lap) begin
`ifdef STOP_WATCH_CTRL_LAP_EN
                    w_next = ST_LAP;
`else
                    w_next = ST_RUN;
`endif
                end
            end
            ST_LAP: begin
`ifdef STOP_WATCH_CTRL_LAP_EN
                if (w_start)    w_next = ST_STOP;
                else if (w_lap) w_next = ST_RUN;
`else
                w_next = ST_IDLE;
`endif
            end
            ST_STOP: begin
                if (w_start)    w_next = ST_RUN;
                else if (w_lap) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Output decode on the next state so outputs track state exactly.
    always_comb begin
        w_en_nx   = (w_next == ST_RUN) || (w_next == ST_LAP);
        w_zero_nx = (r_state == ST_STOP) && (w_next == ST_IDLE);
`ifdef STOP_WATCH_CTRL_LAP_EN
        w_hold_nx = (w_next == ST_LAP);
`else
        w_hold_nx = 1'b0;
`endif
    end

    assign enable   = r_enable;
    assign zero     = r_zero;
    assign lap_hold = r_lap_hold;
    assign state    = r_state;

endmodule

// File: doc/stop_watch_ctrl.md
STOP_WATCH_CTRL -- requirements
Module: stop_watch_ctrl

Interface
REQ-001 Parameter: DEB_CYCLES, default 20, number of consecutive stable clk cycles required to accept a button level change (range 2..1023).
REQ-002 clk  input  1  single system clock; the 1 kHz tick domain shared with the downstream stopwatch counter.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 btn_start  input  1  raw start/stop push button, active-high, asynchronous to clk, bouncy.
REQ-005 btn_lap  input  1  raw lap/clear push button, active-high, asynchronous to clk, bouncy.
REQ-006 enable  output  1  count-enable to the downstream stopwatch counter; registered.
REQ-007 zero  output  1  clear request to the downstream counter; single-cycle pulse; registered.
REQ-008 lap_hold  output  1  display freeze request: the display stage holds its last shown time while high; registered.
REQ-009 state  output  2  current FSM state, encoded per the shared package.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer, then a debouncer whose level flips only after the synchronized value differs from the level for DEB_CYCLES consecutive cycles; any mismatch-free cycle restarts the count.
REQ-011 A press event SHALL be a one-cycle pulse on the rising edge of the debounced level; release produces no event.
REQ-012 FSM states: IDLE, RUN, STOP, LAP.
REQ-013 IDLE: start -> RUN; lap ignored.
REQ-014 RUN: start -> STOP; lap -> LAP.
REQ-015 LAP: lap -> RUN; start -> STOP.
REQ-016 STOP: start -> RUN; lap -> IDLE.
REQ-017 If start and lap events occur in the same cycle, start SHALL win and lap SHALL be discarded.
REQ-018 enable SHALL be 1 exactly in RUN and LAP.
REQ-019 lap_hold SHALL be 1 exactly in LAP.
REQ-020 zero SHALL pulse high for exactly one cycle, in the cycle after the STOP->IDLE transition edge; zero and enable are never high together.
REQ-021 Latency: outputs change exactly DEB_CYCLES+3 clk cycles after a clean raw button rise.
REQ-022 A held button SHALL produce exactly one event regardless of hold duration.

Reset
REQ-023 While rst=1 at a clk edge: state=IDLE, enable=0, zero=0, lap_hold=0, synchronizers=0, debounced levels=0, debounce counters=0.
REQ-024 Reset mid-operation (any state) SHALL take effect at the next edge without emitting a zero pulse.
REQ-025 A button held through reset release SHALL be debounced afresh and SHALL yield one event after DEB_CYCLES+3 cycles.

Configuration
REQ-026 Macro STOP_WATCH_CTRL_LAP_EN defined: LAP state and lap_hold behave per REQ-014/015/019.
REQ-027 Macro undefined: LAP is unreachable, lap in RUN is ignored, lap_hold is tied 0; the lap button acts only as clear from STOP.

Structure
REQ-028 Package stop_watch_pkg SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, STOP=2'd2, LAP=2'd3) and the DEB_CYCLES default constant.
REQ-029 Sub-module btn_debounce (synchronizer + debouncer + edge pulse, parameter DEB_CYCLES) SHALL be instantiated twice.

Verification (DEB_CYCLES=4 throughout)
REQ-030 Clean btn_start rise from IDLE, held 20 cycles -> enable=1 exactly 7 cycles later, state=RUN; a single event only.
REQ-031 btn_start bouncing 1,0,1,0 for 3 cycles, then stable 1 -> no event until 4 stable cycles; exactly one transition IDLE->RUN.
REQ-032 Sequence start, lap, lap, start, lap -> states RUN, LAP (lap_hold=1), RUN, STOP, IDLE; zero is high for exactly 1 cycle after the final transition; enable=0 throughout the zero pulse.
REQ-033 Start and lap events in the same cycle while in RUN -> STOP; no LAP entry.
REQ-034 rst=1 asserted for 1 cycle while in LAP -> next cycle state=IDLE, enable=0, lap_hold=0, zero=0.
REQ-035 Build without STOP_WATCH_CTRL_LAP_EN, lap pressed in RUN -> stays RUN, lap_hold=0; lap pressed in STOP -> IDLE plus a zero pulse.
